// File: rtl/dcache_miss_ctrl_pkg.sv
// Shared data-cache geometry and miss-controller state encoding.
// Geometry values must match the 4-way data array ports.
package dcache_miss_ctrl_pkg;

    localparam int DC_TAG_W  = 20;
    localparam int DC_IDX_W  = 8;
    localparam int DC_OFF_W  = 4;
    localparam int DC_DATA_W = 128;
    localparam int DC_CNT_W  = 32;
    localparam int DC_ADDR_W = DC_TAG_W + DC_IDX_W + DC_OFF_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MREQ  = 3'd1,
        ST_MWAIT = 3'd2,
        ST_FILL  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/sat_cnt.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
// Shared by the dcache, icache and DTLB miss statistics.
module sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (i_en && !(&cnt_q)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Single-outstanding load controller: probes the data array, refills
// on a miss over the memory bus, writes the fill and returns the line.
module dcache_miss_ctrl
    import dcache_miss_ctrl_pkg::*;
#(
    parameter int TAG_W  = DC_TAG_W,
    parameter int IDX_W  = DC_IDX_W,
    parameter int OFF_W  = DC_OFF_W,
    parameter int DATA_W = DC_DATA_W,
    parameter int ADDR_W = TAG_W + IDX_W + OFF_W,
    parameter int CNT_W  = DC_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_lsu_req_vld,
    output logic              o_lsu_req_rdy,
    input  logic [ADDR_W-1:0] i_lsu_req_addr,
    output logic              o_lsu_rsp_vld,
    output logic [DATA_W-1:0] o_lsu_rsp_dat,
    output logic              o_lsu_rsp_err,
    input  logic              i_lsu_rsp_rdy,
    output logic              o_dc_req,
    output logic [TAG_W-1:0]  o_dc_rtag,
    output logic [IDX_W-1:0]  o_dc_ridx,
    input  logic              i_dc_hit,
    input  logic [DATA_W-1:0] i_dc_rdat,
    output logic              o_dc_wren,
    output logic [IDX_W-1:0]  o_dc_widx,
    output logic [TAG_W-1:0]  o_dc_wtag,
    output logic [DATA_W-1:0] o_dc_wdat,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvld,
    input  logic [DATA_W-1:0] i_mem_rdat,
    input  logic              i_mem_rerr,
    output logic [CNT_W-1:0]  o_miss_cnt
);

    state_e            state_q;
    logic [TAG_W-1:0]  tag_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] line_q;
    logic              err_q;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic              unused_off;
    logic              is_idle, is_mreq, is_fill, is_resp;
    logic              miss_inc;

    assign req_tag    = i_lsu_req_addr[ADDR_W-1:IDX_W+OFF_W];
    assign req_idx    = i_lsu_req_addr[IDX_W+OFF_W-1:OFF_W];
    // Loads are line-granular; the byte offset never leaves the LSU.
    assign unused_off = ^i_lsu_req_addr[OFF_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tag_q   <= '0;
            idx_q   <= '0;
            line_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_lsu_req_vld) begin
                        tag_q <= req_tag;
                        idx_q <= req_idx;
                        if (i_dc_hit) begin
                            line_q  <= i_dc_rdat;
                            err_q   <= 1'b0;
                            state_q <= ST_RESP;
                        end else begin
                            state_q <= ST_MREQ;
                        end
                    end
                end
                // A data beat coincident with the grant is dropped: the bus
                // never returns data before granting.
                ST_MREQ: begin
                    if (i_mem_gnt) state_q <= ST_MWAIT;
                end
                ST_MWAIT: begin
                    if (i_mem_rvld) begin
                        if (i_mem_rerr) begin
                            line_q  <= '0;
                            err_q   <= 1'b1;
                            state_q <= ST_RESP;
                        end else begin
                            line_q  <= i_mem_rdat;
                            err_q   <= 1'b0;
                            state_q <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_lsu_rsp_rdy) state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign is_idle  = (state_q == ST_IDLE);
    assign is_mreq  = (state_q == ST_MREQ);
    assign is_fill  = (state_q == ST_FILL);
    assign is_resp  = (state_q == ST_RESP);
    assign miss_inc = is_idle && i_lsu_req_vld && !i_dc_hit;

    sat_cnt #(
        .W(CNT_W)
    ) u_miss_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .i_en (miss_inc),
        .o_cnt(o_miss_cnt)
    );

    // Probe path is live only in IDLE; elsewhere it parks on the latched line.
    assign o_lsu_req_rdy = is_idle;
    assign o_dc_req      = is_idle && i_lsu_req_vld;
    assign o_dc_rtag     = is_idle ? req_tag : tag_q;
    assign o_dc_ridx     = is_idle ? req_idx : idx_q;

    assign o_lsu_rsp_vld = is_resp;
    assign o_lsu_rsp_dat = is_resp ? line_q : '0;
    assign o_lsu_rsp_err = is_resp && err_q;

    assign o_dc_wren     = is_fill;
    assign o_dc_widx     = is_fill ? idx_q  : '0;
    assign o_dc_wtag     = is_fill ? tag_q  : '0;
    assign o_dc_wdat     = is_fill ? line_q : '0;

    assign o_mem_req     = is_mreq;
    assign o_mem_addr    = is_mreq ? {tag_q, idx_q, {OFF_W{1'b0}}} : '0;

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Bench for dcache_miss_ctrl: directed vector table, randomized
// transactions against a transaction-level model, and reset corners.
module tb_dcache_miss_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_vld = 1'b0;
    logic         req_rdy;
    logic [31:0]  req_addr = '0;
    logic         rsp_vld;
    logic [127:0] rsp_dat;
    logic         rsp_err;
    logic         rsp_rdy = 1'b0;
    logic         dc_req;
    logic [19:0]  dc_rtag;
    logic [7:0]   dc_ridx;
    logic         dc_hit = 1'b0;
    logic [127:0] dc_rdat = '0;
    logic         dc_wren;
    logic [7:0]   dc_widx;
    logic [19:0]  dc_wtag;
    logic [127:0] dc_wdat;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_gnt = 1'b0;
    logic         mem_rvld = 1'b0;
    logic [127:0] mem_rdat = '0;
    logic         mem_rerr = 1'b0;
    logic [31:0]  miss_cnt;

    always #5 clk = ~clk;

    dcache_miss_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_lsu_req_vld (req_vld),
        .o_lsu_req_rdy (req_rdy),
        .i_lsu_req_addr(req_addr),
        .o_lsu_rsp_vld (rsp_vld),
        .o_lsu_rsp_dat (rsp_dat),
        .o_lsu_rsp_err (rsp_err),
        .i_lsu_rsp_rdy (rsp_rdy),
        .o_dc_req      (dc_req),
        .o_dc_rtag     (dc_rtag),
        .o_dc_ridx     (dc_ridx),
        .i_dc_hit      (dc_hit),
        .i_dc_rdat     (dc_rdat),
        .o_dc_wren     (dc_wren),
        .o_dc_widx     (dc_widx),
        .o_dc_wtag     (dc_wtag),
        .o_dc_wdat     (dc_wdat),
        .o_mem_req     (mem_req),
        .o_mem_addr    (mem_addr),
        .i_mem_gnt     (mem_gnt),
        .i_mem_rvld    (mem_rvld),
        .i_mem_rdat    (mem_rdat),
        .i_mem_rerr    (mem_rerr),
        .o_miss_cnt    (miss_cnt)
    );

    typedef struct {
        logic [31:0]  addr;
        logic         hit;
        logic [127:0] hdat;
        logic [127:0] mdat;
        logic         merr;
        logic         junk;   // stray rvld (with rerr) while waiting for grant
        int           gd;     // cycles before grant
        int           rd;     // cycles from grant to data, >= 1
        int           bp;     // cycles of response backpressure
        logic [127:0] edat;
        logic         eerr;
        int           ewren;
        int           emreq;
        int           emiss;
    } vec_t;

    int total = 0;
    int bad = 0;
    int wren_n = 0;
    int mreq_n = 0;
    logic [19:0]  w_tag;
    logic [7:0]   w_idx;
    logic [127:0] w_dat;

    always @(negedge clk) begin
        if (dc_wren) begin
            wren_n++;
            w_tag = dc_wtag;
            w_idx = dc_widx;
            w_dat = dc_wdat;
        end
        if (mem_req) mreq_n++;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(logic [31:0] a, logic h, logic [127:0] hd, logic [127:0] md,
                                logic me, logic j, int gd, int rd, int bp,
                                logic [127:0] ed, logic ee, int ew, int emr, int ems);
        vec_t v;
        v.addr = a; v.hit = h; v.hdat = hd; v.mdat = md; v.merr = me; v.junk = j;
        v.gd = gd; v.rd = rd; v.bp = bp;
        v.edat = ed; v.eerr = ee; v.ewren = ew; v.emreq = emr; v.emiss = ems;
        return v;
    endfunction

    // Drives one load through the DUT as LSU + array + bus, then checks it.
    task automatic run_vec(input vec_t v, input string p);
        int to;
        int w0, m0;
        logic [127:0] d0;
        logic e0;
        logic [31:0] line;
        line = {v.addr[31:4], 4'h0};
        to = 0;
        while (!req_rdy && to < 50) begin tick(); to++; end
        chk({p, ".rdy"}, req_rdy, 1);
        w0 = wren_n;
        m0 = mreq_n;
        req_vld = 1'b1; req_addr = v.addr; dc_hit = v.hit; dc_rdat = v.hdat;
        #1;
        chk({p, ".probe"}, dc_req, 1);
        chk({p, ".rtag"}, dc_rtag, v.addr[31:12]);
        chk({p, ".ridx"}, dc_ridx, v.addr[11:4]);
        tick();
        req_vld = 1'b0; dc_hit = 1'b0; dc_rdat = '0; req_addr = $urandom;
        #1;
        chk({p, ".busy"}, {req_rdy, dc_req}, 2'b00);
        chk({p, ".rtag_lat"}, dc_rtag, v.addr[31:12]);
        if (v.hit) begin
            chk({p, ".hit_lat"}, rsp_vld, 1);
        end else begin
            chk({p, ".mreq"}, mem_req, 1);
            chk({p, ".maddr"}, mem_addr, line);
            mem_rvld = v.junk; mem_rerr = v.junk; mem_rdat = ~v.mdat;
            for (int c = 0; c < v.gd; c++) begin
                tick();
                chk({p, ".maddr_hold"}, {mem_req, mem_addr}, {1'b1, line});
            end
            mem_gnt = 1'b1;
            tick();
            mem_gnt = 1'b0; mem_rvld = 1'b0; mem_rerr = 1'b0;
            chk({p, ".mwait"}, {mem_req, rsp_vld, dc_wren}, 3'b000);
            for (int c = 0; c < v.rd - 1; c++) tick();
            mem_rvld = 1'b1; mem_rdat = v.mdat; mem_rerr = v.merr;
            tick();
            mem_rvld = 1'b0; mem_rerr = 1'b0; mem_rdat = '0;
        end
        to = 0;
        while (!rsp_vld && to < 30) begin tick(); to++; end
        chk({p, ".rsp_vld"}, rsp_vld, 1);
        d0 = rsp_dat;
        e0 = rsp_err;
        for (int c = 0; c < v.bp; c++) begin
            chk({p, ".bp_ctl"}, {rsp_vld, req_rdy}, 2'b10);
            chk({p, ".bp_dat"}, {rsp_err, rsp_dat}, {e0, d0});
            tick();
        end
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
        chk({p, ".after"}, {rsp_vld, req_rdy}, 2'b01);
        chk({p, ".dat"}, d0, v.edat);
        chk({p, ".err"}, e0, v.eerr);
        chk({p, ".wren_n"}, wren_n - w0, v.ewren);
        chk({p, ".memreq"}, (mreq_n != m0) ? 1 : 0, v.emreq);
        if (v.ewren != 0) begin
            chk({p, ".wtag"}, w_tag, v.addr[31:12]);
            chk({p, ".widx"}, w_idx, v.addr[11:4]);
            chk({p, ".wdat"}, w_dat, v.mdat);
        end
        chk({p, ".miss"}, miss_cnt, v.emiss);
    endtask

    initial begin
        vec_t tbl[5];
        vec_t v;
        int miss_ref;
        int w0;
        logic [127:0] aa, ff55, f0;
        aa   = {16{8'hAA}};
        ff55 = {16{8'h55}};
        f0   = {16{8'h0F}};

        tbl[0] = mk(32'h12345A70, 1, aa, '0, 0, 0, 0, 1, 0, aa, 0, 0, 0, 0);
        tbl[1] = mk(32'h12345A70, 0, '0, ff55, 0, 0, 3, 5, 0, ff55, 0, 1, 1, 1);
        tbl[2] = mk(32'hDEADBEEF, 0, '0, 128'h1234, 1, 0, 0, 1, 2, '0, 1, 0, 1, 2);
        tbl[3] = mk(32'hCAFE0010, 1, f0, '0, 0, 0, 0, 1, 4, f0, 0, 0, 0, 2);
        tbl[4] = mk(32'h00ABC123, 0, '0, ~ff55, 0, 1, 2, 1, 0, ~ff55, 0, 1, 1, 3);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst.rdy", req_rdy, 1);
        chk("rst.ctl", {rsp_vld, rsp_err, dc_req, dc_wren, mem_req}, 5'b0);
        chk("rst.dat", rsp_dat, '0);
        chk("rst.probe", {dc_rtag, dc_ridx}, '0);
        chk("rst.fill", {dc_wtag, dc_widx, dc_wdat}, '0);
        chk("rst.maddr", mem_addr, '0);
        chk("rst.miss", miss_cnt, '0);

        for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
        miss_ref = 3;

        for (int i = 0; i < 40; i++) begin
            v.addr = $urandom;
            v.hit  = 1'($urandom_range(0, 1));
            v.hdat = {$urandom, $urandom, $urandom, $urandom};
            v.mdat = {$urandom, $urandom, $urandom, $urandom};
            v.merr = ($urandom_range(0, 3) == 0);
            v.junk = 1'($urandom_range(0, 1));
            v.gd   = $urandom_range(0, 4);
            v.rd   = $urandom_range(1, 4);
            v.bp   = $urandom_range(0, 3);
            if (v.hit) begin
                v.edat = v.hdat; v.eerr = 0; v.ewren = 0; v.emreq = 0;
            end else begin
                miss_ref++;
                v.edat  = v.merr ? '0 : v.mdat;
                v.eerr  = v.merr;
                v.ewren = v.merr ? 0 : 1;
                v.emreq = 1;
            end
            v.emiss = miss_ref;
            run_vec(v, $sformatf("rnd%0d", i));
        end

        // Reset while waiting for refill data, then a stray beat afterwards.
        req_vld = 1'b1; req_addr = 32'h0BAD0F00; dc_hit = 1'b0;
        tick();
        req_vld = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        tick();
        chk("mrst.inwait", {mem_req, req_rdy, rsp_vld}, 3'b000);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst.async", {req_rdy, rsp_vld, mem_req}, 3'b100);
        chk("mrst.miss", miss_cnt, '0);
        @(negedge clk);
        rst_n = 1'b1;
        w0 = wren_n;
        mem_rvld = 1'b1; mem_rdat = aa;
        tick();
        mem_rvld = 1'b0; mem_rdat = '0;
        tick();
        chk("mrst.stray", {dc_wren, rsp_vld, req_rdy}, 3'b001);
        chk("mrst.nofill", wren_n - w0, 0);
        chk("mrst.miss2", miss_cnt, '0);
        run_vec(mk(32'h0BAD0F00, 1, f0, '0, 0, 0, 0, 1, 1, f0, 0, 0, 0, 0), "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
